redmule_ctx_ctrl: RTL

REDMULE_CTX_CTRL -- requirements
Module: redmule_ctx_ctrl

---
 rtl/redmule_ctx_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/redmule_ctx_ctrl.sv
// Job-context controller for the RedMulE accelerator: queues job submissions, sequences
// the active job through setup/compute, and raises per-core done/error events.
module redmule_ctx_ctrl #(
    parameter int unsigned N_CORES   = 8,
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned CFG_WIDTH = 32,
    parameter int unsigned TIMEOUT_W = 16,
    localparam int unsigned ID_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1,
    localparam int unsigned LVL_W    = $clog2(N_CONTEXT + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [ID_W-1:0]           core_id_i,
    input  logic [CFG_WIDTH-1:0]      cfg_i,
    input  logic                      red_en_i,
    output logic                      accept_o,
    output logic [LVL_W-1:0]          level_o,
    output logic [CFG_WIDTH-1:0]      cfg_o,
    input  logic                      cfg_ready_i,
    input  logic                      w_loaded_i,
    input  logic                      z_done_i,
    input  logic                      r_done_i,
    input  logic                      abort_i,
    input  logic [TIMEOUT_W-1:0]      timeout_i,
    output logic                      busy_o,
    output logic                      idle_o,
    output logic                      clear_o,
    output logic                      flush_o,
    output logic                      first_load_o,
    output logic                      finished_o,
    output logic [N_CORES-1:0][1:0]   evt_o
);

    localparam int unsigned PTR_W = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;

    typedef enum logic [2:0] {
        StRst,
        StIdle,
        StSetup,
        StStarting,
        StComputing,
        StFinished,
        StError
    } state_e;

    state_e                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [LVL_W-1:0]       level_q;
    logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
    logic [ID_W-1:0]        fifo_id_q  [N_CONTEXT];
    logic [CFG_WIDTH-1:0]   fifo_cfg_q [N_CONTEXT];
    logic                   fifo_red_q [N_CONTEXT];
    logic [ID_W-1:0]        act_id_q;
    logic [CFG_WIDTH-1:0]   act_cfg_q;
    logic                   act_red_q;

    logic push, pop, abort_flush, timeout_hit, job_done;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_CONTEXT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept_o    = (level_q < LVL_W'(N_CONTEXT));
    assign push        = start_i && accept_o && !abort_flush;
    assign timeout_hit = (timeout_i != '0) && (cnt_q == timeout_i);
    assign job_done    = z_done_i && (!act_red_q || r_done_i);

    // Priority in the active states: abort, then completion, then watchdog, then hold.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        abort_flush = 1'b0;
        unique case (state_q)
            StRst: state_d = StIdle;
            StIdle: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (abort_i) begin
                    abort_flush = 1'b1;
                    state_d     = StError;
                end else if (cfg_ready_i) begin
                    cnt_d   = '0;
                    state_d = StStarting;
                end
            end
            StStarting, StComputing: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (abort_i) begin
                    abort_flush = 1'b1;
                    state_d     = StError;
                end else if (state_q == StStarting && w_loaded_i) begin
                    state_d = StComputing;
                end else if (state_q == StComputing && job_done) begin
                    state_d = StFinished;
                end else if (timeout_hit) begin
                    state_d = StError;
                end
            end
            StFinished, StError: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StRst;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StRst;
            cnt_q     <= '0;
            level_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            act_id_q  <= '0;
            act_cfg_q <= '0;
            act_red_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (abort_flush) begin
                level_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    fifo_id_q[wr_ptr_q]  <= core_id_i;
                    fifo_cfg_q[wr_ptr_q] <= cfg_i;
                    fifo_red_q[wr_ptr_q] <= red_en_i;
                    wr_ptr_q             <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    act_id_q  <= fifo_id_q[rd_ptr_q];
                    act_cfg_q <= fifo_cfg_q[rd_ptr_q];
                    act_red_q <= fifo_red_q[rd_ptr_q];
                    rd_ptr_q  <= ptr_inc(rd_ptr_q);
                end
                if (push && !pop) begin
                    level_q <= level_q + 1'b1;
                end else if (!push && pop) begin
                    level_q <= level_q - 1'b1;
                end
            end
        end
    end

    assign level_o      = level_q;
    assign cfg_o        = act_cfg_q;
    assign idle_o       = (state_q == StRst) || (state_q == StIdle);
    assign busy_o       = !idle_o || (level_q != '0);
    assign first_load_o = (state_q == StStarting);
    assign flush_o      = (state_q == StFinished) || (state_q == StError);
    assign finished_o   = flush_o;
    assign clear_o      = (state_q == StRst) || flush_o;

    // Ids at or above N_CORES match no index, so such jobs run silently.
    always_comb begin
        evt_o = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (act_id_q == ID_W'(i)) begin
                evt_o[i][0] = (state_q == StFinished);
                evt_o[i][1] = (state_q == StError);
            end
        end
    end

endmodule
